// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM drive stage fed by signed wheel speed commands.
// Shared 11-bit timebase, per-side duty latched at the period boundary,
// per-side dead-time interlock producing non-overlapping PWM pairs.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   lft_spd         signed 11-bit left speed command
//   rght_spd        signed 11-bit right speed command
//   lftPWM1/2       left forward / reverse drive pair
//   rghtPWM1/2      right forward / reverse drive pair
//   pwm_synch       one-cycle pulse while the timebase is at 0
//
// Parameter DEAD: dead-time in clocks, 1..63.
// Build option MTR_DRV_DEADTIME_EN: when defined, the dead-time interlock
// is compiled in; when undefined, each pair is a plain complementary
// output and DEAD has no effect on behaviour.

// One side of the drive: raw compare, one-cycle pipeline, optional
// dead-time counter, registered complementary outputs.
module mtr_drv_side #(
  parameter int DEAD = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] cnt,
  input  logic [10:0] duty,
  output logic        pwm1,
  output logic        pwm2
);

  if (DEAD < 1 || DEAD > 63) begin : g_dead_range
    $error("mtr_drv_side: DEAD must be within 1..63");
  end

  logic raw;
  logic raw_q;

  // Unsigned compare: duty 0 never drives forward, duty 2047 drops
  // only for the last count of the period.
  assign raw = (cnt < duty);

`ifdef MTR_DRV_DEADTIME_EN

  localparam logic [5:0] DEAD_C = 6'(DEAD);

  logic [5:0] dcnt;
  logic       settled;

  // Outputs are enabled only after raw_q has been stable for DEAD
  // cycles, which opens the low-low gap around every transition.
  assign settled = (dcnt == DEAD_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= 1'b0;
      dcnt  <= '0;
      pwm1  <= 1'b0;
      pwm2  <= 1'b0;
    end else begin
      raw_q <= raw;
      if (raw != raw_q) begin
        dcnt <= '0;
      end else if (!settled) begin
        dcnt <= dcnt + 6'd1;
      end
      pwm1 <= raw_q & settled;
      pwm2 <= ~raw_q & settled;
    end
  end

`else

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= 1'b0;
      pwm1  <= 1'b0;
      pwm2  <= 1'b0;
    end else begin
      raw_q <= raw;
      pwm1  <= raw_q;
      pwm2  <= ~raw_q;
    end
  end

`endif

endmodule

module mtr_drv #(
  parameter int DEAD = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] lft_spd,
  input  logic signed [10:0] rght_spd,
  output logic               lftPWM1,
  output logic               lftPWM2,
  output logic               rghtPWM1,
  output logic               rghtPWM2,
  output logic               pwm_synch
);

  localparam logic [10:0] MID = 11'h400;
  localparam logic [10:0] TOP = 11'h7ff;

  logic [10:0] cnt;
  logic [10:0] lft_duty;
  logic [10:0] rght_duty;
  logic        wrap;

  assign wrap = (cnt == TOP);

  // Timebase and period-boundary duty latch. Offsetting the signed
  // command by half scale maps 0 to 50 % duty; the sum wraps mod 2048.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lft_duty  <= MID;
      rght_duty <= MID;
      pwm_synch <= 1'b0;
    end else begin
      cnt       <= cnt + 11'd1;
      pwm_synch <= wrap;
      if (wrap) begin
        lft_duty  <= $unsigned(lft_spd) + MID;
        rght_duty <= $unsigned(rght_spd) + MID;
      end
    end
  end

  mtr_drv_side #(
    .DEAD (DEAD)
  ) u_lft (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .duty (lft_duty),
    .pwm1 (lftPWM1),
    .pwm2 (lftPWM2)
  );

  mtr_drv_side #(
    .DEAD (DEAD)
  ) u_rght (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .duty (rght_duty),
    .pwm1 (rghtPWM1),
    .pwm2 (rghtPWM2)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: scoreboard bench for mtr_drv.
// Expectations are queued per observable; a negedge monitor pops them.
module tb_mtr_drv;

`ifdef MTR_DRV_DEADTIME_EN
  localparam int DT = 32;
`else
  localparam int DT = 0;
`endif

  localparam int NCH = 14;

  logic               clk;
  logic               rst;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;
  logic               lftPWM1;
  logic               lftPWM2;
  logic               rghtPWM1;
  logic               rghtPWM2;
  logic               pwm_synch;

  mtr_drv #(
    .DEAD (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .lftPWM1   (lftPWM1),
    .lftPWM2   (lftPWM2),
    .rghtPWM1  (rghtPWM1),
    .rghtPWM2  (rghtPWM2),
    .pwm_synch (pwm_synch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channels:
  //  0..3  pulse widths of lftPWM1, lftPWM2, rghtPWM1, rghtPWM2
  //  4     clocks between pwm_synch pulses (or reset to first pulse)
  //  5..8  per-period high counts of the four outputs
  //  9,10  per-period both-low counts, left and right
  //  11    per-period both-high count over both pairs
  //  12    lftPWM1 fall position, clocks after pwm_synch
  //  13    outputs in the first cycle after reset
  int    expq [NCH][$];
  string cname [NCH] = '{
    "l1_width", "l2_width", "r1_width", "r2_width",
    "synch_interval",
    "l1_period_high", "l2_period_high",
    "r1_period_high", "r2_period_high",
    "l_both_low", "r_both_low", "both_high",
    "l1_fall_pos", "post_reset_out"
  };

  int vectors = 0;
  int fails   = 0;

  task automatic emit(input int ch, input int val);
    int e;
    if (expq[ch].size() > 0) begin
      e = expq[ch].pop_front();
      vectors++;
      if (val != e) begin
        fails++;
        $display("FAIL %s: got %0d, expected %0d at t=%0t",
                 cname[ch], val, e, $time);
      end
    end
  endtask

  // Monitor state
  logic [3:0] cur;
  logic [3:0] prv;
  logic       prst;
  logic       inwin;
  int         run [4];
  int         hc [4];
  int         blc [2];
  int         bhc;
  int         pcnt;

  initial begin
    prv   = '0;
    prst  = 1'b0;
    inwin = 1'b0;
    pcnt  = 0;
    bhc   = 0;
    for (int i = 0; i < 4; i++) begin
      run[i] = 0;
      hc[i]  = 0;
    end
    blc[0] = 0;
    blc[1] = 0;
  end

  always @(negedge clk) begin
    cur = {rghtPWM2, rghtPWM1, lftPWM2, lftPWM1};
    if (rst) begin
      prv   = '0;
      prst  = 1'b1;
      inwin = 1'b1;
      pcnt  = 0;
      bhc   = 0;
      blc[0] = 0;
      blc[1] = 0;
      for (int i = 0; i < 4; i++) begin
        run[i] = 0;
        hc[i]  = 0;
      end
    end else begin
      if (prst) emit(13, int'({pwm_synch, cur}));
      prst = 1'b0;
      if (pwm_synch) begin
        if (inwin) begin
          emit(4, pcnt);
          for (int i = 0; i < 4; i++) emit(5 + i, hc[i]);
          emit(9, blc[0]);
          emit(10, blc[1]);
          emit(11, bhc);
        end
        inwin = 1'b1;
        pcnt  = 0;
        bhc   = 0;
        blc[0] = 0;
        blc[1] = 0;
        for (int i = 0; i < 4; i++) hc[i] = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (cur[i] && !prv[i]) begin
          run[i] = 1;
        end else if (cur[i]) begin
          run[i]++;
        end else if (prv[i]) begin
          emit(i, run[i]);
          if (i == 0) emit(12, pcnt);
        end
        if (cur[i]) hc[i]++;
      end
      if (!cur[0] && !cur[1]) blc[0]++;
      if (!cur[2] && !cur[3]) blc[1]++;
      if ((cur[0] && cur[1]) || (cur[2] && cur[3])) bhc++;
      pcnt++;
      prv = cur;
    end
  end

  // Expected per-period figures for one side at a given duty.
  task automatic model(input int duty, output int p1,
                       output int p2, output int bl);
    if (duty == 0) begin
      p1 = 0;
      p2 = 2048;
      bl = 0;
    end else if (duty == 2047) begin
      p1 = 2047 - DT;
      p2 = (DT > 0) ? 0 : 1;
      bl = (DT > 0) ? DT + 1 : 0;
    end else begin
      p1 = duty - DT;
      p2 = 2048 - duty - DT;
      bl = 2 * DT;
    end
  endtask

  task automatic push_period(input int ld, input int rd);
    int p1, p2, bl;
    model(ld, p1, p2, bl);
    expq[5].push_back(p1);
    expq[6].push_back(p2);
    expq[9].push_back(bl);
    model(rd, p1, p2, bl);
    expq[7].push_back(p1);
    expq[8].push_back(p2);
    expq[10].push_back(bl);
    expq[11].push_back(0);
    expq[4].push_back(2048);
  endtask

  task automatic push_widths(input int l1, input int l2,
                             input int r1, input int r2);
    expq[0].push_back(l1);
    expq[1].push_back(l2);
    expq[2].push_back(r1);
    expq[3].push_back(r2);
  endtask

  // Post-reset pulses: forward pulse of the first period, plus the
  // reverse pulse that closes at the start of the next period.
  task automatic push_after_reset();
    expq[4].push_back(2048);
    expq[0].push_back(1024 - DT);
    expq[2].push_back(1024 - DT);
    if (DT > 0) begin
      expq[1].push_back(1024 - DT);
      expq[3].push_back(1024 - DT);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NCH; i++) s += expq[i].size();
    return s;
  endfunction

  task automatic wait_synch();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pwm_synch && n < 4200);
    if (!pwm_synch) begin
      vectors++;
      fails++;
      $display("FAIL synch_timeout: no pwm_synch within %0d clocks", n);
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    int e;
    while (pending() > 0 && n < 6200) begin
      @(negedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < NCH; i++) begin
      while (expq[i].size() > 0) begin
        e = expq[i].pop_front();
        vectors++;
        fails++;
        $display("FAIL %s: got no event, expected %0d", cname[i], e);
      end
    end
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: bench exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r;
    rst      = 1'b1;
    lft_spd  = '0;
    rght_spd = '0;
    expq[13].push_back(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push_after_reset();
    drain();

    // Zero command: 50 % duty on both sides
    wait_synch();
    push_period(1024, 1024);
    expq[12].push_back(1026);
    push_widths(1024 - DT, 1024 - DT, 1024 - DT, 1024 - DT);
    drain();

    // +512 / -512: duty 1536 / 512
    lft_spd  = 11'sd512;
    rght_spd = -11'sd512;
    wait_synch();
    wait_synch();
    push_period(1536, 512);
    expq[12].push_back(1538);
    push_widths(1536 - DT, 512 - DT, 512 - DT, 1536 - DT);
    drain();

    // Mid-period change 0 -> +256 at cnt 100 applies next period
    lft_spd  = '0;
    rght_spd = '0;
    wait_synch();
    wait_synch();
    push_period(1024, 1024);
    expq[5].push_back(1280 - DT);
    expq[0].push_back(1024 - DT);
    expq[0].push_back(1280 - DT);
    repeat (100) @(posedge clk);
    #1 lft_spd = 11'sd256;
    drain();

    // Full reverse left (duty 0), full forward right (duty 2047)
    lft_spd  = 11'(-1024);
    rght_spd = 11'sd1023;
    wait_synch();
    wait_synch();
    push_period(0, 2047);
    drain();

    // Mirror of the above
    lft_spd  = 11'sd1023;
    rght_spd = 11'(-1024);
    wait_synch();
    wait_synch();
    push_period(2047, 0);
    drain();

    // Reset at cnt 700 under random commands
    r        = int'($urandom_range(2046)) - 1023;
    lft_spd  = 11'(r);
    r        = int'($urandom_range(2046)) - 1023;
    rght_spd = 11'(r);
    wait_synch();
    wait_synch();
    repeat (700) @(posedge clk);
    #1 rst = 1'b1;
    expq[13].push_back(0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_after_reset();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
